// File: rtl/acc_sort_feeder_if.sv
// Host and accelerator signal bundle for acc_sort_feeder.
// ACC_SORT_FEEDER_CHECK_EN adds the sort_err status line.
interface acc_sort_feeder_if #(
  parameter int DW = 32
);
  logic          host_wr_en;
  logic [DW-1:0] host_wr_data;
  logic          start;
  logic          res_rd_en;
  logic [DW-1:0] res_rd_data;
  logic          res_empty;
  logic          busy;
  logic          done;
  logic          overflow;
  logic          start_err;
  logic [DW-1:0] acc_data_o;
  logic          acc_data_valid;
  logic          func_sel;
  logic [DW-1:0] sort_in;
`ifdef ACC_SORT_FEEDER_CHECK_EN
  logic          sort_err;

  modport master (
    output host_wr_en, host_wr_data, start, res_rd_en, sort_in,
    input  res_rd_data, res_empty, busy, done, overflow, start_err,
    input  acc_data_o, acc_data_valid, func_sel, sort_err
  );

  modport slave (
    input  host_wr_en, host_wr_data, start, res_rd_en, sort_in,
    output res_rd_data, res_empty, busy, done, overflow, start_err,
    output acc_data_o, acc_data_valid, func_sel, sort_err
  );
`else
  modport master (
    output host_wr_en, host_wr_data, start, res_rd_en, sort_in,
    input  res_rd_data, res_empty, busy, done, overflow, start_err,
    input  acc_data_o, acc_data_valid, func_sel
  );

  modport slave (
    input  host_wr_en, host_wr_data, start, res_rd_en, sort_in,
    output res_rd_data, res_empty, busy, done, overflow, start_err,
    output acc_data_o, acc_data_valid, func_sel
  );
`endif
endinterface

// File: rtl/acc_sort_feeder.sv
// Host-side operand feeder and result collector for the N_WORDS sort accelerator.
// Optional ascending-order check of captured results: ACC_SORT_FEEDER_CHECK_EN.
module acc_sort_feeder #(
  parameter int N_WORDS = 10,
  parameter int DW      = 32,
  parameter int RES_LAT = 3
) (
  input logic              clk,
  input logic              rst,
  acc_sort_feeder_if.slave bus
);
  // state | meaning
  // IDLE  | accept host operand writes, wait for start
  // FEED  | stream in_buf to the accelerator, one beat per cycle
  // WAIT  | count down the accelerator result latency
  // CAPT  | capture N_WORDS result words from sort_in
  // DONE  | results readable; next job may be loaded and started

  localparam int CW = $clog2(N_WORDS + 1);
  localparam int IW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int LW = (RES_LAT > 1) ? $clog2(RES_LAT) : 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(N_WORDS);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_WORDS - 1);
  localparam logic [LW-1:0] LAT_LOAD = LW'(RES_LAT - 1);
  localparam logic [LW-1:0] LAT_TC   = LW'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FEED = 3'd1,
    S_WAIT = 3'd2,
    S_CAPT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0] in_buf_q  [N_WORDS];
  logic [DW-1:0] res_buf_q [N_WORDS];
  logic [DW-1:0] res_buf_d [N_WORDS];

  logic [CW-1:0] wr_cnt_q, wr_cnt_d, wr_cnt_upd;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [IW-1:0] feed_cnt_q, feed_cnt_d;
  logic [IW-1:0] cap_cnt_q, cap_cnt_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          overflow_q, overflow_d;
  logic          start_err_q, start_err_d;

  logic host_active, wr_acc, wr_ovf, start_ok, start_bad, pop;
  logic feed_last, cap_last, lat_tc;

  assign host_active = (state_q == S_IDLE) || (state_q == S_DONE);
  assign wr_acc      = host_active && bus.host_wr_en && (wr_cnt_q != CNT_FULL);
  assign wr_ovf      = host_active && bus.host_wr_en && (wr_cnt_q == CNT_FULL);
  // A write in the same cycle as start counts toward the full check.
  assign wr_cnt_upd  = wr_cnt_q + CW'(wr_acc);
  assign start_ok    = host_active && bus.start && (wr_cnt_upd == CNT_FULL);
  assign start_bad   = host_active && bus.start && (wr_cnt_upd != CNT_FULL);
  assign pop         = (state_q == S_DONE) && bus.res_rd_en && (rd_ptr_q != CNT_FULL);
  assign feed_last   = (feed_cnt_q == IDX_LAST);
  assign cap_last    = (cap_cnt_q == IDX_LAST);
  assign lat_tc      = (lat_cnt_q == LAT_TC);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) state_d = S_FEED;
      end
      S_FEED: begin
        if (feed_last) state_d = (RES_LAT == 1) ? S_CAPT : S_WAIT;
      end
      S_WAIT: begin
        if (lat_tc) state_d = S_CAPT;
      end
      S_CAPT: begin
        if (cap_last) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.acc_data_valid = 1'b0;
    bus.acc_data_o     = '0;
    bus.func_sel       = 1'b0;
    bus.busy           = 1'b0;
    bus.done           = 1'b0;
    unique case (state_q)
      S_FEED: begin
        bus.acc_data_valid = 1'b1;
        bus.acc_data_o     = in_buf_q[feed_cnt_q];
        bus.func_sel       = 1'b1;
        bus.busy           = 1'b1;
      end
      S_WAIT, S_CAPT: begin
        bus.func_sel = 1'b1;
        bus.busy     = 1'b1;
      end
      S_DONE: begin
        bus.done = 1'b1;
      end
      default: ;
    endcase
    bus.res_empty = !((state_q == S_DONE) && (rd_ptr_q != CNT_FULL));
  end

  // Datapath next-state
  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    feed_cnt_d  = feed_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    res_buf_d   = res_buf_q;
    overflow_d  = overflow_q | wr_ovf;
    start_err_d = start_err_q | start_bad;

    if (wr_acc) wr_cnt_d = wr_cnt_upd;
    if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;

    if (start_ok) begin
      feed_cnt_d = '0;
      cap_cnt_d  = '0;
      rd_ptr_d   = '0;
      res_buf_d  = '{default: '0};
    end

    unique case (state_q)
      S_FEED: begin
        feed_cnt_d = feed_last ? '0 : feed_cnt_q + 1'b1;
        lat_cnt_d  = LAT_LOAD;
      end
      S_WAIT: begin
        lat_cnt_d = lat_cnt_q - 1'b1;
      end
      S_CAPT: begin
        res_buf_d[cap_cnt_q] = bus.sort_in;
        cap_cnt_d            = cap_last ? '0 : cap_cnt_q + 1'b1;
        if (cap_last) wr_cnt_d = '0;
      end
      default: ;
    endcase

    // Read port always mirrors the slot rd_ptr will point at next cycle.
    rd_data_d = (rd_ptr_d != CNT_FULL) ? res_buf_d[rd_ptr_d[IW-1:0]] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q    <= '0;
      rd_ptr_q    <= '0;
      feed_cnt_q  <= '0;
      cap_cnt_q   <= '0;
      lat_cnt_q   <= '0;
      res_buf_q   <= '{default: '0};
      rd_data_q   <= '0;
      overflow_q  <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      feed_cnt_q  <= feed_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      res_buf_q   <= res_buf_d;
      rd_data_q   <= rd_data_d;
      overflow_q  <= overflow_d;
      start_err_q <= start_err_d;
    end
  end

  // Operand storage needs no reset; wr_cnt gates every use.
  always_ff @(posedge clk) begin
    if (wr_acc) in_buf_q[wr_cnt_q[IW-1:0]] <= bus.host_wr_data;
  end

  assign bus.res_rd_data = rd_data_q;
  assign bus.overflow    = overflow_q;
  assign bus.start_err   = start_err_q;

`ifdef ACC_SORT_FEEDER_CHECK_EN
  logic          sort_err_q, sort_err_d;
  logic [IW-1:0] cap_prev;

  assign cap_prev = cap_cnt_q - 1'b1;

  always_comb begin
    sort_err_d = sort_err_q;
    if (start_ok) begin
      sort_err_d = 1'b0;
    end else if ((state_q == S_CAPT) && (cap_cnt_q != '0) &&
                 (bus.sort_in < res_buf_q[cap_prev])) begin
      sort_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sort_err_q <= 1'b0;
    end else begin
      sort_err_q <= sort_err_d;
    end
  end

  assign bus.sort_err = sort_err_q;
`endif

endmodule

// File: doc/acc_sort_feeder.md
Name: acc_sort_feeder

Overview:
- Host-side transmitter and collector for the 10-word sort accelerator.
- Buffers N_WORDS operands written by the host, then streams them one per cycle on acc_data_o/acc_data_valid with func_sel asserted.
- Captures the accelerator's result stream (SORT_OUT) at a fixed latency into a result buffer the host reads back, then signals done.

Parameters:
- N_WORDS, 10, operands per job; must equal the accelerator's array depth.
- DW, 32, data width.
- RES_LAT, 3, clock edges from the edge transferring the last operand beat to the edge capturing the first result word.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- host_wr_en  in  1  write one operand into the input buffer
- host_wr_data  in  DW  operand
- start  in  1  one-cycle pulse; launch job
- res_rd_en  in  1  pop one result word
- res_rd_data  out  DW  current result word (registered)
- res_empty  out  1  result buffer empty
- busy  out  1  job in progress (FEED, WAIT or CAPT)
- done  out  1  job complete; results readable
- overflow  out  1  sticky; host write attempted while input buffer full
- start_err  out  1  sticky; start received with fewer than N_WORDS operands loaded
- acc_data_o  out  DW  operand to accelerator
- acc_data_valid  out  1  operand beat valid
- func_sel  out  1  selects sort function in accelerator
- sort_in  in  DW  accelerator result stream (SORT_OUT)

Behaviour:
- Reset is synchronous, active-high (rst sampled on clk rising edge); no asynchronous reset anywhere.
- Reset values:
  - state=IDLE; wr_cnt=0, rd_ptr=0, cap_cnt=0, lat_cnt=0.
  - acc_data_valid=0, func_sel=0, acc_data_o=0.
  - busy=0, done=0, overflow=0, start_err=0.
  - res_rd_data=0, res_empty=1.
- IDLE:
  - host_wr_en writes host_wr_data at in_buf[wr_cnt] and increments wr_cnt.
  - If wr_cnt==N_WORDS, the write is dropped and overflow is set.
  - start with wr_cnt==N_WORDS -> FEED; clears done, result buffer and rd_ptr.
  - start with wr_cnt<N_WORDS -> stays in IDLE and sets start_err.
- FEED:
  - acc_data_valid=1, func_sel=1, acc_data_o=in_buf[k] for k=0..N_WORDS-1 on consecutive cycles; no gaps.
  - After the Nth beat: acc_data_valid=0, acc_data_o=0, func_sel stays 1 → WAIT.
- WAIT:
  - Counts RES_LAT-1 edges, then → CAPT.
  - The first capture edge is therefore exactly RES_LAT edges after the last-beat edge.
- CAPT:
  - Captures sort_in into res_buf[cap_cnt] on N_WORDS consecutive edges.
  - After the last capture: → DONE; func_sel=0, wr_cnt=0.
- DONE:
  - done=1, busy=0.
  - res_rd_data presents res_buf[rd_ptr]; res_rd_en advances rd_ptr.
  - res_empty=1 once rd_ptr==N_WORDS; res_rd_en when empty is ignored.
  - Host writes are accepted (next job's operands); start behaves as in IDLE.
- res_rd_data updates on the cycle after the pop (registered), and always reflects res_buf[rd_ptr].
- host_wr_en, start and res_rd_en are ignored while busy=1. Same-cycle host_wr_en and start in IDLE: the write is applied first, then start is evaluated with the updated wr_cnt.
- overflow and start_err clear only on rst.
- Reset mid-job: acc_data_valid drops on the next cycle, all counters clear, buffered data is discarded. The accelerator must be reset alongside, since it holds partial state.

Optional Feature:
- Macro: ACC_SORT_FEEDER_CHECK_EN.
- Defined:
  - Adds output sort_err (1 bit, reset 0, sticky).
  - During CAPT, each captured word is compared unsigned against the previous captured word; sort_err is set if word[i] < word[i-1].
  - sort_err clears on start of a new job.
- Undefined: no port, no comparator logic.

Test Plan:
- Write 10 operands 7,3,9,1,0,5,2,8,6,4; pulse start → 10 consecutive acc_data_valid beats in write order; after RES_LAT, results 0..9 captured; done=1; ten pops read 0,1,...,9; res_empty=1 after the tenth.
- Write 11 operands → overflow=1, 11th dropped; a start then runs the job using the first 10 words.
- Write 4 operands, pulse start → start_err=1, state stays IDLE, acc_data_valid never asserted.
- Assert rst at the 5th FEED beat → next cycle acc_data_valid=0, busy=0, wr_cnt=0; a fresh 10-word job afterwards completes correctly.
- Two back-to-back jobs (load during DONE): second job's results replace the first; done deasserts on the second start.
- With ACC_SORT_FEEDER_CHECK_EN defined, a stub returning 1,2,5,4,... → sort_err=1; a stub returning ascending 0..9 → sort_err=0.
